// File: rtl/flit_rx_ctrl.sv
// flit_rx_ctrl: per-port packet receiver with framing/parity/destination checks and a one-shot start/finish/result handshake
module flit_rx_ctrl #(
  parameter int DATA_W = 16,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0,
  parameter int MAX_FLITS = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [DATA_W-1:0]                  in_flit,
  input  logic                               in_parity,
  output logic                               in_ready,
  input  logic                               ready,
  input  logic                               accept,
  output logic                               start,
  output logic                               finish,
  output logic                               result,
  output logic                               pkt_done,
  output logic                               pkt_ok,
  output logic                               err_frame,
  output logic [$clog2(MAX_FLITS+1)-1:0]     flit_cnt
);
  localparam int CW = $clog2(MAX_FLITS + 1);
  localparam logic [1:0] LX = 2'(LOCAL_X);
  localparam logic [1:0] LY = 2'(LOCAL_Y);
  typedef enum logic [1:0] {IDLE, RECV, ACK, CLR} state_t;
  state_t state, state_nx;
  logic start_nx, finish_nx, result_nx, done_nx, ok_nx, err_nx;
  logic [CW-1:0] cnt_nx;
  logic xfer, par_ok, dst_ok, is_head, is_tail;
  assign in_ready = !rst && ((state == IDLE && ready) || state == RECV);
  assign xfer     = in_valid && in_ready;
  assign par_ok   = (^in_flit) == in_parity;
  assign dst_ok   = in_flit[3:2] == LX && in_flit[1:0] == LY;
  assign is_head  = in_flit[DATA_W-2];
  assign is_tail  = in_flit[DATA_W-1];
  always_comb begin
    state_nx  = state;
    start_nx  = start;
    finish_nx = finish;
    result_nx = result;
    cnt_nx    = flit_cnt;
    ok_nx     = pkt_ok;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: if (xfer) begin
        if (is_head) begin
          start_nx  = 1'b1;
          finish_nx = is_tail;
          result_nx = par_ok && dst_ok;
          cnt_nx    = CW'(1);
          state_nx  = is_tail ? ACK : RECV;
        end else begin
          err_nx = 1'b1;
        end
      end
      RECV: if (xfer) begin
        if (is_head) begin
          result_nx = 1'b0;
          finish_nx = 1'b1;
          err_nx    = 1'b1;
          state_nx  = ACK;
        end else begin
          cnt_nx    = flit_cnt + 1'b1;
          result_nx = result && par_ok;
          if (is_tail) begin
            finish_nx = 1'b1;
            state_nx  = ACK;
          end else if (flit_cnt == CW'(MAX_FLITS - 1)) begin
            result_nx = 1'b0;
            finish_nx = 1'b1;
            err_nx    = 1'b1;
            state_nx  = ACK;
          end
        end
      end
      ACK: begin
        start_nx  = 1'b0;
        finish_nx = 1'b0;
        result_nx = 1'b0;
        cnt_nx    = '0;
        done_nx   = 1'b1;
        ok_nx     = accept;
        state_nx  = CLR;
      end
      CLR: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start     <= 1'b0;
      finish    <= 1'b0;
      result    <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      err_frame <= 1'b0;
      flit_cnt  <= '0;
    end else begin
      state     <= state_nx;
      start     <= start_nx;
      finish    <= finish_nx;
      result    <= result_nx;
      pkt_done  <= done_nx;
      pkt_ok    <= ok_nx;
      err_frame <= err_nx;
      flit_cnt  <= cnt_nx;
    end
  end
endmodule
